// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer.
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback. It drives the datapath mux selects and write enables, and
// uses a req/ready handshake to a shared instruction/data memory.
// Ports:
//   clk, reset (async, active-high), run (start/continue), opcode (IR[31:26])
//   mem_ready / mem_req, iord, mem_read, mem_write   : memory handshake
//   ir_write, pc_write, pc_write_cond, pc_source      : IR / PC control
//   alu_src_a, alu_src_b, alu_op, sign_zero           : ALU control
//   reg_dst, mem_to_reg, reg_write                    : register file control
//   instr_retired, retired_count (saturating)         : retirement
//   illegal_op, mem_timeout (sticky), state (debug)
module mips_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned RETIRE_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                sign_zero,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_retired,
  output logic [RETIRE_W-1:0] retired_count,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int unsigned    WCW      = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT - 1);

  state_e                state_q, state_d;
  logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [RETIRE_W-1:0]   retired_count_q, retired_count_d;
  logic                  illegal_op_q, illegal_op_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic                  retire, timeout, illegal, mem_wait;

  always_comb begin
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    sign_zero     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    timeout       = 1'b0;
    illegal       = 1'b0;
    mem_wait      = 1'b0;
    state_d       = state_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        mem_wait  = 1'b1;
        // mem_ready wins over a timeout in the same cycle
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_cnt_q == WAIT_MAX) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:         state_d = S_EXEC;
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_ORI:  state_d = S_IEXEC;
          OP_J:             state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_cnt_q == WAIT_MAX) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        mem_wait  = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
        end else if (wait_cnt_q == WAIT_MAX) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          alu_op    = 2'b11;
          sign_zero = 1'b1;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) state_d = run ? S_FETCH : S_IDLE;

    // Counter restarts whenever the state changes, so every memory state
    // starts its wait budget from zero.
    if (state_d != state_q)        wait_cnt_d = '0;
    else if (mem_wait && !mem_ready) wait_cnt_d = wait_cnt_q + WCW'(1);
    else                           wait_cnt_d = wait_cnt_q;

    retired_count_d = retired_count_q;
    if (retire && (retired_count_q != '1))
      retired_count_d = retired_count_q + RETIRE_W'(1);

    illegal_op_d  = illegal_op_q | illegal;
    mem_timeout_d = mem_timeout_q | timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wait_cnt_q      <= '0;
      retired_count_q <= '0;
      illegal_op_q    <= 1'b0;
      mem_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      retired_count_q <= retired_count_d;
      illegal_op_q    <= illegal_op_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  assign instr_retired = retire;
  assign retired_count = retired_count_q;
  assign illegal_op    = illegal_op_q;
  assign mem_timeout   = mem_timeout_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl (WAIT_LIMIT=3, RETIRE_W=4).
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write;
  logic       pc_write_cond, alu_src_a, sign_zero, reg_dst, mem_to_reg;
  logic       reg_write, instr_retired, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] retired_count;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_LIMIT(3), .RETIRE_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .sign_zero(sign_zero), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_retired(instr_retired), .retired_count(retired_count),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  // All control outputs packed for whole-vector comparisons:
  // {mem_req,iord,mem_read,mem_write,ir_write,pc_write,pc_write_cond,
  //  pc_source,alu_src_a,alu_src_b,alu_op,sign_zero,reg_dst,mem_to_reg,
  //  reg_write,instr_retired}
  function automatic logic [18:0] ctl();
    return {mem_req, iord, mem_read, mem_write, ir_write, pc_write,
            pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
            sign_zero, reg_dst, mem_to_reg, reg_write, instr_retired};
  endfunction

  // Drive inputs at the falling edge; outputs are observed 1 time unit later.
  task automatic cyc(input logic r, input logic rdy, input logic [5:0] op);
    @(negedge clk);
    run = r; mem_ready = rdy; opcode = op;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    #3;
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (ctl() !== '0) begin n_bad++; $display("FAIL reset_ctl got %b want 0", ctl()); end
    n_cmp++; if ({retired_count, illegal_op, mem_timeout} !== 6'd0) begin
      n_bad++; $display("FAIL reset_cnt_flags got %b want 0", {retired_count, illegal_op, mem_timeout}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw();
    do_reset();
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL lw_idle got %0d want 0", state); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd1) begin n_bad++; $display("FAIL lw_fetch_state got %0d want 1", state); end
    n_cmp++; if (ctl() !== 19'b1010_1100_0001_00000_00) begin
      n_bad++; $display("FAIL lw_fetch_ctl got %b want 1010110000010000000", ctl()); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd2 || alu_src_b !== 2'b11 || alu_src_a !== 1'b0) begin
      n_bad++; $display("FAIL lw_decode got st=%0d b=%b a=%b want st=2 b=11 a=0", state, alu_src_b, alu_src_a); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd3 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin
      n_bad++; $display("FAIL lw_memadr got st=%0d b=%b a=%b want st=3 b=10 a=1", state, alu_src_b, alu_src_a); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd4 || mem_req !== 1'b1 || mem_read !== 1'b1 || iord !== 1'b1) begin
      n_bad++; $display("FAIL lw_memrd got st=%0d req=%b rd=%b iord=%b want 4 1 1 1", state, mem_req, mem_read, iord); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd5 || reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 ||
                 instr_retired !== 1'b1 || retired_count !== 4'd0) begin
      n_bad++; $display("FAIL lw_memwb got st=%0d rw=%b m2r=%b dst=%b ret=%b cnt=%0d want 5 1 1 0 1 0",
                        state, reg_write, mem_to_reg, reg_dst, instr_retired, retired_count); end
    cyc(1, 1, OP_LW);
    n_cmp++; if (state !== 4'd1 || retired_count !== 4'd1 || instr_retired !== 1'b0) begin
      n_bad++; $display("FAIL lw_after got st=%0d cnt=%0d ret=%b want 1 1 0", state, retired_count, instr_retired); end
  endtask

  // Continues from test_lw: next instruction is mid-flight in FETCH.
  task automatic test_reset_mid_memrd();
    cyc(1, 1, OP_LW);
    cyc(1, 1, OP_LW);
    cyc(1, 0, OP_LW);
    n_cmp++; if (state !== 4'd4 || retired_count !== 4'd1) begin
      n_bad++; $display("FAIL midrd_pre got st=%0d cnt=%0d want 4 1", state, retired_count); end
    reset = 1'b1;
    #1;
    n_cmp++; if (state !== 4'd0 || ctl() !== '0 || retired_count !== 4'd0) begin
      n_bad++; $display("FAIL midrd_async got st=%0d ctl=%b cnt=%0d want 0 0 0", state, ctl(), retired_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype_fetch_wait();
    do_reset();
    cyc(1, 0, OP_RTYPE);
    cyc(1, 0, OP_RTYPE);
    n_cmp++; if (state !== 4'd1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      n_bad++; $display("FAIL rt_wait1 got st=%0d irw=%b pcw=%b want 1 0 0", state, ir_write, pc_write); end
    cyc(1, 0, OP_RTYPE);
    n_cmp++; if (state !== 4'd1 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      n_bad++; $display("FAIL rt_wait2 got st=%0d irw=%b pcw=%b want 1 0 0", state, ir_write, pc_write); end
    cyc(1, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd1 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
      n_bad++; $display("FAIL rt_fetch3 got st=%0d irw=%b pcw=%b want 1 1 1", state, ir_write, pc_write); end
    cyc(1, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd2) begin n_bad++; $display("FAIL rt_decode got %0d want 2", state); end
    cyc(1, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd7 || alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
      n_bad++; $display("FAIL rt_exec got st=%0d op=%b a=%b b=%b want 7 10 1 00", state, alu_op, alu_src_a, alu_src_b); end
    cyc(0, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0 || instr_retired !== 1'b1) begin
      n_bad++; $display("FAIL rt_aluwb got st=%0d rw=%b dst=%b m2r=%b ret=%b want 8 1 1 0 1",
                        state, reg_write, reg_dst, mem_to_reg, instr_retired); end
    cyc(0, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd0 || retired_count !== 4'd1 || mem_timeout !== 1'b0) begin
      n_bad++; $display("FAIL rt_end got st=%0d cnt=%0d to=%b want 0 1 0", state, retired_count, mem_timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(1, 0, OP_RTYPE);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, OP_RTYPE);
      n_cmp++; if (state !== 4'd1 || ir_write !== 1'b0 || mem_timeout !== 1'b0) begin
        n_bad++; $display("FAIL to_wait%0d got st=%0d irw=%b to=%b want 1 0 0", i, state, ir_write, mem_timeout); end
    end
    cyc(0, 0, OP_RTYPE);
    n_cmp++; if (state !== 4'd0 || mem_timeout !== 1'b1 || retired_count !== 4'd0) begin
      n_bad++; $display("FAIL to_hit got st=%0d to=%b cnt=%0d want 0 1 0", state, mem_timeout, retired_count); end
    cyc(0, 0, OP_RTYPE);
    n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b want 1", mem_timeout); end
    // Ready on the last allowed cycle beats the timeout
    do_reset();
    cyc(1, 0, OP_RTYPE);
    cyc(1, 0, OP_RTYPE);
    cyc(1, 0, OP_RTYPE);
    cyc(1, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd1 || ir_write !== 1'b1) begin
      n_bad++; $display("FAIL to_edge_fetch got st=%0d irw=%b want 1 1", state, ir_write); end
    cyc(0, 1, OP_RTYPE);
    n_cmp++; if (state !== 4'd2 || mem_timeout !== 1'b0) begin
      n_bad++; $display("FAIL to_edge_decode got st=%0d to=%b want 2 0", state, mem_timeout); end
  endtask

  task automatic test_sw();
    do_reset();
    cyc(1, 1, OP_SW);
    cyc(1, 1, OP_SW);
    cyc(1, 1, OP_SW);
    cyc(1, 1, OP_SW);
    cyc(1, 0, OP_SW);
    n_cmp++; if (state !== 4'd6 || mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0 || instr_retired !== 1'b0) begin
      n_bad++; $display("FAIL sw_wait got st=%0d wr=%b iord=%b rd=%b ret=%b want 6 1 1 0 0",
                        state, mem_write, iord, mem_read, instr_retired); end
    cyc(0, 1, OP_SW);
    n_cmp++; if (state !== 4'd6 || instr_retired !== 1'b1) begin
      n_bad++; $display("FAIL sw_done got st=%0d ret=%b want 6 1", state, instr_retired); end
    cyc(0, 1, OP_SW);
    n_cmp++; if (state !== 4'd0 || retired_count !== 4'd1) begin
      n_bad++; $display("FAIL sw_end got st=%0d cnt=%0d want 0 1", state, retired_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    cyc(1, 1, OP_BAD);
    cyc(1, 1, OP_BAD);
    cyc(0, 1, OP_BAD);
    n_cmp++; if (state !== 4'd2 || illegal_op !== 1'b0) begin
      n_bad++; $display("FAIL ill_decode got st=%0d ill=%b want 2 0", state, illegal_op); end
    cyc(0, 1, OP_BAD);
    n_cmp++; if (state !== 4'd0 || illegal_op !== 1'b1 || retired_count !== 4'd0 || instr_retired !== 1'b0) begin
      n_bad++; $display("FAIL ill_end got st=%0d ill=%b cnt=%0d ret=%b want 0 1 0 0",
                        state, illegal_op, retired_count, instr_retired); end
  endtask

  task automatic test_branch_ori();
    do_reset();
    cyc(1, 1, OP_BEQ);
    cyc(1, 1, OP_BEQ);
    cyc(1, 1, OP_BEQ);
    cyc(1, 1, OP_ORI);
    n_cmp++; if (state !== 4'd9 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01 ||
                 pc_write !== 1'b0 || instr_retired !== 1'b1) begin
      n_bad++; $display("FAIL beq got st=%0d pwc=%b src=%b op=%b pcw=%b ret=%b want 9 1 01 01 0 1",
                        state, pc_write_cond, pc_source, alu_op, pc_write, instr_retired); end
    cyc(1, 1, OP_ORI);
    n_cmp++; if (state !== 4'd1 || retired_count !== 4'd1) begin
      n_bad++; $display("FAIL beq_next got st=%0d cnt=%0d want 1 1", state, retired_count); end
    cyc(1, 1, OP_ORI);
    cyc(1, 1, OP_ORI);
    n_cmp++; if (state !== 4'd10 || alu_op !== 2'b11 || sign_zero !== 1'b1 || alu_src_b !== 2'b10) begin
      n_bad++; $display("FAIL ori_exec got st=%0d op=%b sz=%b b=%b want 10 11 1 10", state, alu_op, sign_zero, alu_src_b); end
    cyc(0, 1, OP_ORI);
    n_cmp++; if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0 || instr_retired !== 1'b1) begin
      n_bad++; $display("FAIL ori_wb got st=%0d rw=%b dst=%b ret=%b want 11 1 0 1", state, reg_write, reg_dst, instr_retired); end
    cyc(0, 1, OP_ORI);
    n_cmp++; if (state !== 4'd0 || retired_count !== 4'd2) begin
      n_bad++; $display("FAIL ori_end got st=%0d cnt=%0d want 0 2", state, retired_count); end
  endtask

  task automatic test_jump_saturate();
    logic [3:0] exp_cnt;
    do_reset();
    cyc(1, 1, OP_J);
    for (int i = 0; i < 17; i++) begin
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      cyc(1, 1, OP_J);
      n_cmp++; if (state !== 4'd1 || retired_count !== exp_cnt) begin
        n_bad++; $display("FAIL j%0d_fetch got st=%0d cnt=%0d want 1 %0d", i, state, retired_count, exp_cnt); end
      cyc(1, 1, OP_J);
      cyc((i == 16) ? 1'b0 : 1'b1, 1, OP_J);
      n_cmp++; if (state !== 4'd12 || pc_write !== 1'b1 || pc_source !== 2'b10 || instr_retired !== 1'b1) begin
        n_bad++; $display("FAIL j%0d_jump got st=%0d pcw=%b src=%b ret=%b want 12 1 10 1",
                          i, state, pc_write, pc_source, instr_retired); end
    end
    cyc(0, 1, OP_J);
    n_cmp++; if (state !== 4'd0 || retired_count !== 4'd15) begin
      n_bad++; $display("FAIL j_saturated got st=%0d cnt=%0d want 0 15", state, retired_count); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_reset_mid_memrd();
    test_rtype_fetch_wait();
    test_timeout();
    test_sw();
    test_illegal();
    test_branch_ori();
    test_jump_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle sequencer for the MIPS datapath built from the existing ALU, muxes and register file. It replaces single-cycle combinational control with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. The FSM drives datapath mux selects, write enables and a req/ready handshake to a shared instruction/data memory. It also keeps a retired-instruction counter and sticky fault flags.

Parameters:
WAIT_LIMIT, 15, maximum cycles a memory state waits for mem_ready before timeout (must be >=1)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
run  input  1  start/continue execution; sampled in IDLE and at instruction end
opcode  input  6  Instruction[31:26] from IR; valid from DECODE onward
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
iord  output  1  0=PC address, 1=ALUOut address
mem_read  output  1  memory read
mem_write  output  1  memory write
ir_write  output  1  load IR
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU Zero
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct field, 11 or
sign_zero  output  1  1=zero-extend immediate
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  1=memory data to regfile
reg_write  output  1  regfile write enable
instr_retired  output  1  one-cycle pulse when an instruction completes
retired_count  output  RETIRE_W  retired instructions, saturating
illegal_op  output  1  sticky: unsupported opcode decoded
mem_timeout  output  1  sticky: memory wait exceeded WAIT_LIMIT
state  output  4  current state code (debug)

Behaviour:
- Reset (async): state=IDLE(0), wait_cnt=0, retired_count=0, illegal_op=0, mem_timeout=0. All control outputs are 0 in IDLE.
- Outputs are decoded from state only. Exceptions: ir_write, pc_write in FETCH and instr_retired in MEMWR are gated by mem_ready. Any output not listed for a state is 0.
- IDLE(0): run=1 -> FETCH.
- FETCH(1): mem_req, mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. On mem_ready -> DECODE.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Dispatch on opcode:
  - 000000 -> EXEC
  - 100011, 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000, 001101 -> IEXEC
  - 000010 -> JUMP
  - any other: set illegal_op, -> IDLE, no retire.
- MEMADR(3): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD(4): mem_req, mem_read, iord=1. On mem_ready -> MEMWB.
- MEMWB(5): reg_write, mem_to_reg=1, reg_dst=0. Retire.
- MEMWR(6): mem_req, mem_write, iord=1. Retire on mem_ready.
- EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB(8): reg_write, reg_dst=1, mem_to_reg=0. Retire.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retire.
- IEXEC(10): alu_src_a=1, alu_src_b=10. alu_op=00 for addi; alu_op=11 and sign_zero=1 for ori. -> IWB.
- IWB(11): reg_write, reg_dst=0, mem_to_reg=0. Retire.
- JUMP(12): pc_write=1, pc_source=10. Retire.
- Codes 13-15 are unreachable; if entered, -> IDLE.
- Retire: instr_retired=1 that cycle; retired_count+1 on the same edge, saturating at all-ones. Next state is FETCH if run=1, else IDLE.
- Deasserting run mid-instruction does not abort; the instruction completes, then the FSM enters IDLE.
- Memory wait (FETCH, MEMRD, MEMWR):
  - wait_cnt clears on state entry and increments each cycle with mem_ready=0.
  - mem_ready=0 with wait_cnt==WAIT_LIMIT-1: set mem_timeout, -> IDLE. No ir_write, pc_write or retire occurs.
  - mem_ready wins over timeout in the same cycle.
- Latency with zero-wait memory: beq/j 3 cycles, R-type/addi/ori/sw 4, lw 5. Each memory wait cycle adds 1.
- Sticky flags clear only on reset.

Test Plan:
- Reset mid-MEMRD (reset pulsed while state=4) -> state=0 immediately (async), all outputs 0, retired_count=0.
- run=1, mem_ready=1, opcode=100011 -> states 1,2,3,4,5,1. instr_retired pulses in cycle 5; retired_count=1; reg_write=1 with mem_to_reg=1 in state 5.
- opcode=000000, mem_ready delayed 2 cycles in FETCH -> FETCH lasts 3 cycles; ir_write=pc_write high only in the 3rd cycle; total 6 cycles to retire.
- WAIT_LIMIT=3, mem_ready=0 in FETCH -> after 3 cycles state=0, mem_timeout=1, ir_write never asserted. Variant with mem_ready=1 on the 3rd cycle -> DECODE, no timeout.
- opcode=111111 -> after DECODE state=0, illegal_op=1, retired_count unchanged.
- RETIRE_W=4, run held high, 17 j instructions (000010) -> retired_count=15 (saturated); pc_source=10 with pc_write=1 in each JUMP cycle.
